// File: rtl/npc_trap_unit_pkg.sv
// Shared encodings for the fetch-stage next-PC selector and trap controller.
// Default vector addresses live here so the top level and any users agree on them.
package npc_trap_unit_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4   = 3'b000,
    NPC_BRANCH  = 3'b001,
    NPC_JUMP    = 3'b010,
    NPC_INT_RET = 3'b011,
    NPC_JALR    = 3'b100
  } npc_op_e;

  // Value of the trap_cause MSB when the trap came from the exception channel
  localparam logic CAUSE_EXC = 1'b1;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0040;
  localparam int          DEF_VEC_STRIDE = 8;
  localparam logic [31:0] DEF_EXC_VEC    = 32'h0000_0050;
  localparam logic [31:0] DEF_FATAL_VEC  = 32'h0000_0008;

endpackage

// File: rtl/npc_trap_unit_trap_epc_stack.sv
// LIFO of saved return PCs; each entry records the PC, whether it came from an
// exception, and the interrupt index. Reads return zero when the stack is empty.
module trap_epc_stack #(
  parameter int XLEN  = 32,
  parameter int IW    = 3,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [XLEN-1:0]                push_pc,
  input  logic                           push_exc,
  input  logic [IW-1:0]                  push_idx,
  output logic [XLEN-1:0]                top_pc,
  output logic                           top_exc,
  output logic [IW-1:0]                  top_idx,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic            exc_mem [DEPTH];
  logic [IW-1:0]   idx_mem [DEPTH];
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign wr_idx = AW'(level);
  assign rd_idx = AW'(level - LW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        exc_mem[i] <= 1'b0;
        idx_mem[i] <= '0;
      end
    end else if (push && !full) begin
      pc_mem[wr_idx]  <= push_pc;
      exc_mem[wr_idx] <= push_exc;
      idx_mem[wr_idx] <= push_idx;
      level           <= level + LW'(1);
    end else if (pop && !empty) begin
      level <= level - LW'(1);
    end
  end

  assign top_pc  = empty ? '0   : pc_mem[rd_idx];
  assign top_exc = empty ? 1'b0 : exc_mem[rd_idx];
  assign top_idx = empty ? '0   : idx_mem[rd_idx];

endmodule

// File: rtl/npc_trap_unit.sv
// Next-PC generator with a prioritised, nestable, vectored trap controller.
// Interrupts latch into pending bits; only strictly higher priority may preempt.
module npc_trap_unit
  import npc_trap_unit_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter int               NUM_SRC     = 8,
  parameter int               STACK_DEPTH = 4,
  parameter logic [XLEN-1:0]  VEC_BASE    = XLEN'(DEF_VEC_BASE),
  parameter int               VEC_STRIDE  = DEF_VEC_STRIDE,
  parameter logic [XLEN-1:0]  EXC_VEC     = XLEN'(DEF_EXC_VEC),
  parameter logic [XLEN-1:0]  FATAL_VEC   = XLEN'(DEF_FATAL_VEC)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [XLEN-1:0]                     PC,
  input  logic [XLEN-1:0]                     PC_EX,
  input  logic [2:0]                          NPCOp,
  input  logic [XLEN-1:0]                     IMM,
  input  logic [XLEN-1:0]                     aluout,
  input  logic                                PCWrite,
  input  logic [NUM_SRC-1:0]                  irq,
  input  logic [NUM_SRC-1:0]                  irq_mask,
  input  logic                                exc_valid,
  output logic [XLEN-1:0]                     NPC,
  output logic                                trap_taken,
  output logic [$clog2(NUM_SRC):0]            trap_cause,
  output logic [$clog2(STACK_DEPTH+1)-1:0]    nest_level,
  output logic [XLEN-1:0]                     epc_top,
  output logic                                overflow
);

  localparam int IW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LVW = IW + 1;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] clear;
  logic               cand_valid;
  logic [IW-1:0]      cand_idx;
  logic [LVW-1:0]     cur_level;
  logic               irq_elig;
  logic               irq_take;
  logic               do_push;
  logic               do_pop;
  logic               st_full;
  logic               st_empty;
  logic               top_exc;
  logic [IW-1:0]      top_idx;
  logic [XLEN-1:0]    top_pc;

  // Lowest enabled pending index wins
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i] && irq_mask[i]) begin
        cand_valid = 1'b1;
        cand_idx   = IW'(i);
      end
    end
  end

  // Exception handlers run at the lowest level so any interrupt may nest on them
  assign cur_level  = (st_empty || top_exc) ? LVW'(NUM_SRC) : {1'b0, top_idx};
  assign irq_elig   = cand_valid && ({1'b0, cand_idx} < cur_level) && !st_full;
  assign trap_taken = PCWrite && (exc_valid || irq_elig);
  assign irq_take   = trap_taken && !exc_valid;
  assign do_push    = trap_taken && !st_full;
  assign do_pop     = PCWrite && (NPCOp == NPC_INT_RET) && !st_empty && !trap_taken;
  assign clear      = irq_take ? (NUM_SRC'(1) << cand_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      overflow   <= 1'b0;
      trap_cause <= '0;
    end else begin
      pending <= (pending | irq) & ~clear;
      if (trap_taken) begin
        trap_cause <= exc_valid ? {CAUSE_EXC, {IW{1'b0}}} : {1'b0, cand_idx};
      end
      if (trap_taken && exc_valid && st_full) begin
        overflow <= 1'b1;
      end
    end
  end

  trap_epc_stack #(
    .XLEN  (XLEN),
    .IW    (IW),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (do_push),
    .pop      (do_pop),
    .push_pc  (PC_EX),
    .push_exc (exc_valid),
    .push_idx (exc_valid ? {IW{1'b0}} : cand_idx),
    .top_pc   (top_pc),
    .top_exc  (top_exc),
    .top_idx  (top_idx),
    .level    (nest_level),
    .full     (st_full),
    .empty    (st_empty)
  );

  assign epc_top = top_pc;

  // Interrupted instructions re-execute; excepting ones are skipped on return
  always_comb begin
    NPC = PC + XLEN'(4);
    if (!PCWrite) begin
      NPC = PC;
    end else if (trap_taken) begin
      if (exc_valid) NPC = st_full ? FATAL_VEC : EXC_VEC;
      else           NPC = VEC_BASE + XLEN'(cand_idx) * XLEN'(VEC_STRIDE);
    end else begin
      case (NPCOp)
        NPC_PLUS4:   NPC = PC + XLEN'(4);
        NPC_BRANCH,
        NPC_JUMP:    NPC = PC_EX + IMM;
        NPC_JALR:    NPC = aluout;
        NPC_INT_RET: if (!st_empty) NPC = top_exc ? top_pc + XLEN'(4) : top_pc;
        default:     NPC = PC + XLEN'(4);
      endcase
    end
  end

endmodule

// File: tb/tb_npc_trap_unit.sv
// Self-checking bench for npc_trap_unit: a table of per-cycle vectors with
// hand-derived expectations, fed through a queue, plus reset/wrap sequences.
module tb_npc_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, PC_EX, IMM, aluout;
  logic [2:0]  NPCOp;
  logic        PCWrite;
  logic [7:0]  irq, irq_mask;
  logic        exc_valid;
  logic [31:0] NPC;
  logic        trap_taken;
  logic [3:0]  trap_cause;
  logic [2:0]  nest_level;
  logic [31:0] epc_top;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  npc_trap_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PC         (PC),
    .PC_EX      (PC_EX),
    .NPCOp      (NPCOp),
    .IMM        (IMM),
    .aluout     (aluout),
    .PCWrite    (PCWrite),
    .irq        (irq),
    .irq_mask   (irq_mask),
    .exc_valid  (exc_valid),
    .NPC        (NPC),
    .trap_taken (trap_taken),
    .trap_cause (trap_cause),
    .nest_level (nest_level),
    .epc_top    (epc_top),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        pcw;
    logic [7:0]  irq;
    logic [7:0]  mask;
    logic        exc;
    logic [31:0] pc;
    logic [31:0] pc_ex;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] exp_npc;
    logic        exp_tt;
    logic [2:0]  exp_nest;
    logic [31:0] exp_epc;
    logic        exp_ovf;
    logic        chk_cause;
    logic [3:0]  exp_cause;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mkv(input string name, input logic [2:0] op, input logic pcw,
                               input logic [7:0] irq_v, input logic exc,
                               input logic [31:0] pc, input logic [31:0] pc_ex,
                               input logic [31:0] npc, input logic tt, input logic [2:0] nest,
                               input logic [31:0] epc, input logic ovf,
                               input logic chk, input logic [3:0] cause);
    vec_t v;
    v.name = name; v.op = op; v.pcw = pcw; v.irq = irq_v; v.mask = 8'hFF; v.exc = exc;
    v.pc = pc; v.pc_ex = pc_ex; v.imm = 32'h100; v.alu = 32'h3000;
    v.exp_npc = npc; v.exp_tt = tt; v.exp_nest = nest; v.exp_epc = epc; v.exp_ovf = ovf;
    v.chk_cause = chk; v.exp_cause = cause;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    NPCOp = v.op; PCWrite = v.pcw; irq = v.irq; irq_mask = v.mask; exc_valid = v.exc;
    PC = v.pc; PC_EX = v.pc_ex; IMM = v.imm; aluout = v.alu;
    exp_q.push_back(v);
  endtask

  task automatic checkComb();
    vec_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q[0];
      check({e.name, ".npc"}, NPC, e.exp_npc);
      check({e.name, ".trap_taken"}, {31'd0, trap_taken}, {31'd0, e.exp_tt});
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({e.name, ".nest_level"}, {29'd0, nest_level}, {29'd0, e.exp_nest});
      check({e.name, ".epc_top"}, epc_top, e.exp_epc);
      check({e.name, ".overflow"}, {31'd0, overflow}, {31'd0, e.exp_ovf});
      if (e.chk_cause) check({e.name, ".trap_cause"}, {28'd0, trap_cause}, {28'd0, e.exp_cause});
    end
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkComb();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".nest_level"}, {29'd0, nest_level}, 32'd0);
    check({tag, ".epc_top"}, epc_top, 32'd0);
    check({tag, ".overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, ".trap_cause"}, {28'd0, trap_cause}, 32'd0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; PC = 32'h1000; PC_EX = 32'h800; NPCOp = 3'b000; IMM = 32'h100;
    aluout = 32'h3000; PCWrite = 1'b1; irq = 8'h00; irq_mask = 8'hFF; exc_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetState("reset");

    // name, op, pcw, irq, exc, pc, pc_ex, npc, tt, nest, epc, ovf, chk_cause, cause
    tbl.push_back(mkv("plus4",       3'd0, 1, 8'h00, 0, 32'h1000, 32'h800, 32'h1004, 0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("branch",      3'd1, 1, 8'h00, 0, 32'h1000, 32'h800, 32'h900,  0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("jump",        3'd2, 1, 8'h00, 0, 32'h1000, 32'h880, 32'h980,  0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("jalr",        3'd4, 1, 8'h00, 0, 32'h1000, 32'h800, 32'h3000, 0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("op_other",    3'd7, 1, 8'h00, 0, 32'h1000, 32'h800, 32'h1004, 0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("ret_empty",   3'd3, 1, 8'h00, 0, 32'h1000, 32'h800, 32'h1004, 0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("stall_plain", 3'd0, 0, 8'h00, 0, 32'h1000, 32'h800, 32'h1000, 0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("irq2_raise",  3'd0, 1, 8'h04, 0, 32'h1000, 32'h800, 32'h1004, 0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("irq2_take",   3'd0, 1, 8'h00, 0, 32'h1004, 32'h120, 32'h50,   1, 1, 32'h120, 0, 1, 4'h2));
    tbl.push_back(mkv("h2_idle",     3'd0, 1, 8'h00, 0, 32'h50,   32'h800, 32'h54,   0, 1, 32'h120, 0, 0, 4'h0));
    tbl.push_back(mkv("ret_irq2",    3'd3, 1, 8'h00, 0, 32'h54,   32'h800, 32'h120,  0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("irq2_raise_b",3'd0, 1, 8'h04, 0, 32'h124,  32'h800, 32'h128,  0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("irq2_take_b", 3'd0, 1, 8'h20, 0, 32'h128,  32'h130, 32'h50,   1, 1, 32'h130, 0, 1, 4'h2));
    tbl.push_back(mkv("irq5_held",   3'd0, 1, 8'h00, 0, 32'h50,   32'h800, 32'h54,   0, 1, 32'h130, 0, 0, 4'h0));
    tbl.push_back(mkv("irq0_raise",  3'd0, 1, 8'h01, 0, 32'h54,   32'h800, 32'h58,   0, 1, 32'h130, 0, 0, 4'h0));
    tbl.push_back(mkv("irq0_preempt",3'd0, 1, 8'h00, 0, 32'h5C,   32'h58,  32'h40,   1, 2, 32'h58,  0, 1, 4'h0));
    tbl.push_back(mkv("h0_idle",     3'd0, 1, 8'h00, 0, 32'h40,   32'h800, 32'h44,   0, 2, 32'h58,  0, 0, 4'h0));
    tbl.push_back(mkv("ret_irq0",    3'd3, 1, 8'h00, 0, 32'h44,   32'h800, 32'h58,   0, 1, 32'h130, 0, 0, 4'h0));
    tbl.push_back(mkv("irq5_still",  3'd0, 1, 8'h00, 0, 32'h58,   32'h800, 32'h5C,   0, 1, 32'h130, 0, 0, 4'h0));
    tbl.push_back(mkv("ret_irq2_b",  3'd3, 1, 8'h00, 0, 32'h5C,   32'h800, 32'h130,  0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("irq5_take",   3'd0, 1, 8'h00, 0, 32'h130,  32'h134, 32'h68,   1, 1, 32'h134, 0, 1, 4'h5));
    tbl.push_back(mkv("ret_irq5",    3'd3, 1, 8'h00, 0, 32'h68,   32'h800, 32'h134,  0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("exc_beats_irq",3'd0,1, 8'h01, 1, 32'h204,  32'h200, 32'h50,   1, 1, 32'h200, 0, 1, 4'h8));
    v = mkv("ret_exc",               3'd3, 1, 8'h00, 0, 32'h50,   32'h800, 32'h204,  0, 0, 32'h0, 0, 0, 4'h0);
    v.mask = 8'hFE;
    tbl.push_back(v);
    tbl.push_back(mkv("irq0_after_exc",3'd0,1,8'h00, 0, 32'h208,  32'h204, 32'h40,   1, 1, 32'h204, 0, 1, 4'h0));
    tbl.push_back(mkv("ret_vs_exc",  3'd3, 1, 8'h00, 1, 32'h48,   32'h44,  32'h50,   1, 2, 32'h44,  0, 1, 4'h8));
    tbl.push_back(mkv("ret_exc_b",   3'd3, 1, 8'h00, 0, 32'h50,   32'h800, 32'h48,   0, 1, 32'h204, 0, 0, 4'h0));
    tbl.push_back(mkv("ret_irq0_b",  3'd3, 1, 8'h00, 0, 32'h48,   32'h800, 32'h204,  0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("stall_irq3",  3'd0, 0, 8'h08, 0, 32'h400,  32'h800, 32'h400,  0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("stall_pend",  3'd0, 0, 8'h00, 0, 32'h400,  32'h800, 32'h400,  0, 0, 32'h0, 0, 0, 4'h0));
    tbl.push_back(mkv("irq3_unstall",3'd0, 1, 8'h00, 0, 32'h400,  32'h3FC, 32'h58,   1, 1, 32'h3FC, 0, 1, 4'h3));
    tbl.push_back(mkv("ret_irq3",    3'd3, 1, 8'h00, 0, 32'h58,   32'h800, 32'h3FC,  0, 0, 32'h0, 0, 0, 4'h0));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mkv($sformatf("exc_fill%0d", i + 1), 3'd0, 1, 8'h00, 1, 32'h500,
                        32'h300 + 32'(i) * 32'h10, 32'h50, 1, 3'(i + 1),
                        32'h300 + 32'(i) * 32'h10, 0, 1, 4'h8));
    end
    tbl.push_back(mkv("exc_overflow",3'd0, 1, 8'h00, 1, 32'h50,   32'h340, 32'h08,   1, 4, 32'h330, 1, 0, 4'h0));
    tbl.push_back(mkv("irq1_raise",  3'd0, 1, 8'h02, 0, 32'h08,   32'h800, 32'h0C,   0, 4, 32'h330, 1, 0, 4'h0));
    tbl.push_back(mkv("irq1_full",   3'd0, 1, 8'h00, 0, 32'h0C,   32'h800, 32'h10,   0, 4, 32'h330, 1, 0, 4'h0));
    tbl.push_back(mkv("ret_full",    3'd3, 1, 8'h00, 0, 32'h10,   32'h800, 32'h334,  0, 3, 32'h320, 1, 0, 4'h0));
    tbl.push_back(mkv("irq1_refill", 3'd0, 1, 8'h00, 0, 32'h334,  32'h338, 32'h48,   1, 4, 32'h338, 1, 1, 4'h1));
    tbl.push_back(mkv("stall_no_pop",3'd3, 0, 8'h00, 0, 32'h48,   32'h800, 32'h48,   0, 4, 32'h338, 1, 0, 4'h0));

    foreach (tbl[i]) runVector(tbl[i]);

    // Reset mid-handler with a request arriving in the same cycle
    rst = 1'b1; irq = 8'h10; NPCOp = 3'b000; PCWrite = 1'b1; exc_valid = 1'b0; irq_mask = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0; irq = 8'h00;
    checkResetState("reset_mid");

    // Branch target wraps; no trap because reset discarded the pending request
    NPCOp = 3'b001; PC = 32'h600; PC_EX = 32'hFFFF_FFF0; IMM = 32'h20;
    @(negedge clk);
    check("wrap.npc", NPC, 32'h10);
    check("wrap.trap_taken", {31'd0, trap_taken}, 32'd0);
    @(posedge clk);
    #1;
    check("wrap.nest_level", {29'd0, nest_level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
